// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word width, sigma rotation and
// shift amounts, the small-sigma helper functions and the schedule state type.
package sha256_pkg;

    localparam int WORD_W = 32;

    // Rotation / shift amounts of the two small-sigma functions
    localparam int SSIG0_ROT_A = 7;
    localparam int SSIG0_ROT_B = 18;
    localparam int SSIG0_SHR   = 3;
    localparam int SSIG1_ROT_A = 17;
    localparam int SSIG1_ROT_B = 19;
    localparam int SSIG1_SHR   = 10;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } sched_state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return rotr(x, SSIG0_ROT_A) ^ rotr(x, SSIG0_ROT_B) ^ (x >> SSIG0_SHR);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return rotr(x, SSIG1_ROT_A) ^ rotr(x, SSIG1_ROT_B) ^ (x >> SSIG1_SHR);
    endfunction

endpackage

// File: rtl/sha256_sched_add4.sv
// Combinational 4-operand mod-2^32 adder for the schedule expansion.
// Build option: SHA256_SCHED_CSA_EN selects a carry-save (two 3:2 compressors
// plus one carry-propagate adder) structure instead of a plain '+' chain.
module sha256_sched_add4
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic [WORD_W-1:0] i_c,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_sum
);

`ifdef SHA256_SCHED_CSA_EN
    logic [WORD_W-1:0] w_s1;
    logic [WORD_W-1:0] w_c1;
    logic [WORD_W-1:0] w_c1_sh;
    logic [WORD_W-1:0] w_s2;
    logic [WORD_W-1:0] w_c2;
    logic [WORD_W-1:0] w_c2_sh;

    // First compressor: a + b + c = s1 + 2*c1 (carry MSB falls off mod 2^32)
    assign w_s1    = i_a ^ i_b ^ i_c;
    assign w_c1    = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign w_c1_sh = {w_c1[WORD_W-2:0], 1'b0};

    // Second compressor folds in the fourth operand
    assign w_s2    = w_s1 ^ w_c1_sh ^ i_d;
    assign w_c2    = (w_s1 & w_c1_sh) | (w_s1 & i_d) | (w_c1_sh & i_d);
    assign w_c2_sh = {w_c2[WORD_W-2:0], 1'b0};

    assign o_sum   = w_s2 + w_c2_sh;
`else
    assign o_sum   = i_a + i_b + i_c + i_d;
`endif

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: echoes W0..W15 from the input stream, then expands
// W16..W(NUM_WORDS-1) from a 16-word sliding window. Single-register output
// slot with valid/ready on both sides.
// Build option: SHA256_SCHED_CSA_EN (carry-save adder inside sha256_sched_add4).
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
    localparam logic [5:0] LOAD_END = 6'd15;

    sched_state_t      r_state;
    logic [5:0]        r_t;
    logic [WORD_W-1:0] r_window [16];   // [15] = W[t-1], [0] = W[t-16]
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_word;
    logic [5:0]        r_out_idx;
    logic              r_out_last;

    logic              w_slot_free;
    logic              w_load_fire;
    logic              w_exp_fire;
    logic              w_advance;
    logic [WORD_W-1:0] w_exp_word;
    logic [WORD_W-1:0] w_new_word;
    logic [WORD_W-1:0] w_window_next [16];

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state == LOAD) && w_slot_free;
    assign w_load_fire = in_valid && in_ready;
    assign w_exp_fire  = (r_state == EXPAND) && w_slot_free;
    assign w_advance   = w_load_fire || w_exp_fire;

    sha256_sched_add4 u_add4 (
        .i_a   (ssig1(r_window[14])),
        .i_b   (r_window[9]),
        .i_c   (ssig0(r_window[1])),
        .i_d   (r_window[0]),
        .o_sum (w_exp_word)
    );

    assign w_new_word = (r_state == LOAD) ? in_word : w_exp_word;

    // Window shifts towards index 0; the newest word enters at index 15
    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
        if (gi == 15) begin : g_head
            assign w_window_next[gi] = w_new_word;
        end else begin : g_body
            assign w_window_next[gi] = r_window[gi+1];
        end
    end

    // Window register: advances only when a word enters the output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= '0;
            end
        end else if (w_advance) begin
            r_window <= w_window_next;
        end
    end

    // State, t counter and output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_t         <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_out_word  <= w_new_word;
            r_out_idx   <= r_t;
            r_out_last  <= (r_t == LAST_IDX);
            if (r_state == LOAD) begin
                if (r_t == LOAD_END) begin
                    r_state <= EXPAND;
                end
                r_t <= r_t + 6'd1;
            end else if (r_t == LAST_IDX) begin
                r_state <= LOAD;
                r_t     <= '0;
            end else begin
                r_t <= r_t + 6'd1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = (r_state == EXPAND) || r_out_valid;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule (NUM_WORDS=64 and NUM_WORDS=17
// instances). Works unchanged with or without SHA256_SCHED_CSA_EN defined.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_word, out_word;
    logic [5:0]  out_idx;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [31:0] s_in_word, s_out_word;
    logic [5:0]  s_out_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk   [2][16];
    logic [31:0] exp_w [2][64];
    logic [31:0] cap_w [128];

    always #5 clk = ~clk;

    sha256_msg_schedule #(.NUM_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    sha256_msg_schedule #(.NUM_WORDS(17)) dut17 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_word(s_in_word),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_word(s_out_word),
        .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy)
    );

    // Reference SHA-256 schedule (FIPS 180-4)
    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input int b);
        for (int i = 0; i < 16; i++) exp_w[b][i] = blk[b][i];
        for (int i = 16; i < 64; i++)
            exp_w[b][i] = m_s1(exp_w[b][i-2]) + exp_w[b][i-7] + m_s0(exp_w[b][i-15]) + exp_w[b][i-16];
    endtask

    task automatic load_abc(input int b);
        for (int i = 0; i < 16; i++) blk[b][i] = 32'h0;
        blk[b][0]  = 32'h61626380;
        blk[b][15] = 32'h00000018;
        build_model(b);
    endtask

    // Streams nblk blocks through the 64-word DUT, checking every consumed word
    task automatic stream_blocks(input int nblk, input int stall_pct, input string name);
        int          ip = 0, op = 0, cyc = 0;
        int          total_in = nblk * 16;
        int          total_out = nblk * 64;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_word = '0;
        logic [5:0]  prev_idx = '0;
        bit          started = 0;
        while (op < total_out && cyc < 3000) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) >= stall_pct);
            in_valid  = (ip < total_in);
            in_word   = in_valid ? blk[ip/16][ip%16] : 32'h0;
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_word !== prev_word || out_idx !== prev_idx) begin
                    errors++;
                    $display("FAIL %s_hold: got v=%b w=%h i=%0d, need v=1 w=%h i=%0d",
                             name, out_valid, out_word, out_idx, prev_word, prev_idx);
                end
            end
            if (stall_pct == 0 && started) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_bubble: out_valid=%b at word %0d, need 1", name, out_valid, op);
                end
            end
            if (out_valid && out_ready) begin
                started = 1;
                checks++;
                if (out_word !== exp_w[op/64][op%64] || out_idx !== 6'(op%64) ||
                    out_last !== logic'((op % 64) == 63)) begin
                    errors++;
                    $display("FAIL %s_word%0d: got w=%h i=%0d l=%b, need w=%h i=%0d l=%b",
                             name, op, out_word, out_idx, out_last, exp_w[op/64][op%64],
                             op % 64, (op % 64) == 63);
                end
                cap_w[op] = out_word;
                if (op == 63 && nblk > 1) begin
                    checks++;
                    if (!(in_valid && in_ready)) begin
                        errors++;
                        $display("FAIL %s_b2b_accept: in_valid=%b in_ready=%b at idx63, need both 1",
                                 name, in_valid, in_ready);
                    end
                end
                op++;
            end
            if (in_valid && in_ready) ip++;
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
            prev_idx   = out_idx;
            cyc++;
        end
        checks++;
        if (op < total_out) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words, need %0d", name, op, total_out);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_word = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || out_idx !== 6'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b w=%h i=%0d l=%b, need 0 0 0 0",
                     out_valid, out_word, out_idx, out_last);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, need 0", busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b with out_ready=0, need 1", in_ready);
        end
    endtask

    task automatic test_abc();
        load_abc(0);
        stream_blocks(1, 0, "abc");
        checks++;
        if (cap_w[16] !== 32'h61626380) begin
            errors++;
            $display("FAIL abc_w16: got %h, need 61626380", cap_w[16]);
        end
        checks++;
        if (cap_w[17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL abc_w17: got %h, need 000f0000", cap_w[17]);
        end
        checks++;
        if (cap_w[18] !== 32'h7DA86405) begin
            errors++;
            $display("FAIL abc_w18: got %h, need 7da86405", cap_w[18]);
        end
    endtask

    task automatic test_backpressure();
        load_abc(0);
        stream_blocks(1, 50, "bp");
    endtask

    task automatic test_back_to_back();
        load_abc(0);
        for (int i = 0; i < 16; i++) blk[1][i] = (32'h01010101 * (i + 1)) ^ 32'hA5A5A5A5;
        build_model(1);
        stream_blocks(2, 0, "b2b");
    endtask

    task automatic test_mid_reset();
        int  ip = 0, cyc = 0;
        bit  hit = 0;
        load_abc(0);
        while (!hit && cyc < 200) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (ip < 16);
            in_word   = in_valid ? blk[0][ip] : 32'h0;
            #1;
            if (out_valid && out_idx == 6'd20) hit = 1;
            else if (in_valid && in_ready) ip++;
            cyc++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_reach: idx 20 not seen, need it within 200 cycles");
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid_state: got v=%b busy=%b rdy=%b i=%0d, need 0 0 1 0",
                     out_valid, busy, in_ready, out_idx);
        end
        stream_blocks(1, 0, "post_rst");
    endtask

    task automatic test_short();
        int          ip = 0, op = 0, cyc = 0;
        logic [31:0] w16_model;
        w16_model = m_s1(32'hFFFFFFFF) + 32'hFFFFFFFF + m_s0(32'hFFFFFFFF) + 32'hFFFFFFFF;
        checks++;
        if (w16_model !== 32'h203FFFFC) begin
            errors++;
            $display("FAIL short_model: model %h, hand value 203ffffc", w16_model);
        end
        while (op < 17 && cyc < 200) begin
            @(negedge clk);
            s_out_ready = 1'b1;
            s_in_valid  = (ip < 16);
            s_in_word   = 32'hFFFFFFFF;
            #1;
            if (s_out_valid && s_out_ready) begin
                checks++;
                if (s_out_idx !== 6'(op) || s_out_last !== logic'(op == 16) ||
                    s_out_word !== ((op == 16) ? 32'h203FFFFC : 32'hFFFFFFFF)) begin
                    errors++;
                    $display("FAIL short_word%0d: got w=%h i=%0d l=%b, need w=%h i=%0d l=%b",
                             op, s_out_word, s_out_idx, s_out_last,
                             (op == 16) ? 32'h203FFFFC : 32'hFFFFFFFF, op, op == 16);
                end
                op++;
            end
            if (s_in_valid && s_in_ready) ip++;
            cyc++;
        end
        checks++;
        if (op != 17) begin
            errors++;
            $display("FAIL short_timeout: got %0d words, need 17", op);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        #1;
        checks++;
        if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_back_to_load: got v=%b busy=%b rdy=%b, need 0 0 1",
                     s_out_valid, s_busy, s_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_short();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
